// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown alarm slice.
// State encoding, field widths and time-field limits.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED,
        ST_ALARM
    } state_t;

    localparam int HH_W = 5;
    localparam int MM_W = 6;
    localparam int SS_W = 6;

    localparam logic [SS_W-1:0] SEC_MAX = 6'd59;
    localparam logic [MM_W-1:0] MIN_MAX = 6'd59;

endpackage

// File: rtl/alarm_stretch.sv
// Stretches a one-cycle trigger into a level ALARM_LEN cycles long.
// Retriggering restarts the count; o_last marks the final high cycle.
module alarm_stretch #(
    parameter int ALARM_LEN = 50
) (
    input  logic i_clk,
    input  logic i_trigger,
    input  logic i_clear,
    output logic o_level,
    output logic o_last
);

    localparam logic [7:0] LEN_M1 = 8'(ALARM_LEN - 1);

    logic [7:0] r_cnt;
    logic       r_level;

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_cnt   <= 8'd0;
            r_level <= 1'b0;
        end else if (i_trigger) begin
            r_cnt   <= LEN_M1;
            r_level <= 1'b1;
        end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end else begin
            r_level <= 1'b0;
        end
    end

    assign o_level = r_level;
    assign o_last  = r_level && (r_cnt == 8'd0);

endmodule

// File: rtl/countdown_alarm.sv
// HH:MM:SS countdown timer with alarm stretch and load/start/pause control.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the shadow value on expiry.
module countdown_alarm
    import countdown_pkg::*;
#(
    parameter int MAX_HOURS = 24,
    parameter int ALARM_LEN = 50
) (
    input  logic            clk_50m,
    input  logic            reset_n,
    input  logic            tick_1s,
    input  logic            load,
    input  logic [HH_W-1:0] load_hh,
    input  logic [MM_W-1:0] load_mm,
    input  logic [SS_W-1:0] load_ss,
    input  logic            start,
    input  logic            pause,
    input  logic            clear,
    output logic [HH_W-1:0] rem_hh,
    output logic [MM_W-1:0] rem_mm,
    output logic [SS_W-1:0] rem_ss,
    output logic            busy,
    output logic            expired,
    output logic            alarm,
    output logic            load_err
);

    state_t          r_state;
    logic [HH_W-1:0] r_hh;
    logic [MM_W-1:0] r_mm;
    logic [SS_W-1:0] r_ss;
    logic [HH_W-1:0] r_sh_hh;
    logic [MM_W-1:0] r_sh_mm;
    logic [SS_W-1:0] r_sh_ss;
    logic            r_expired;
    logic            r_load_err;

    logic [HH_W-1:0] w_dec_hh;
    logic [MM_W-1:0] w_dec_mm;
    logic [SS_W-1:0] w_dec_ss;
    logic            w_rem_zero;
    logic            w_rem_one;
    logic            w_load_ok;
    logic            w_editable;
    logic            w_tick_run;
    logic            w_trig;
    logic            w_clr;
    logic            w_level;
    logic            w_last;

    always_comb begin
        w_dec_hh = r_hh;
        w_dec_mm = r_mm;
        w_dec_ss = r_ss;
        if (r_ss != '0) begin
            w_dec_ss = r_ss - 6'd1;
        end else begin
            w_dec_ss = SEC_MAX;
            if (r_mm != '0) begin
                w_dec_mm = r_mm - 6'd1;
            end else begin
                w_dec_mm = MIN_MAX;
                w_dec_hh = r_hh - 5'd1;
            end
        end
    end

    assign w_rem_zero = (r_hh == '0) && (r_mm == '0) && (r_ss == '0);
    assign w_rem_one  = (r_hh == '0) && (r_mm == '0) && (r_ss == 6'd1);
    assign w_load_ok  = (int'(load_hh) < MAX_HOURS)
                     && (load_mm <= MIN_MAX)
                     && (load_ss <= SEC_MAX);
    assign w_editable = (r_state == ST_IDLE) || (r_state == ST_PAUSED);

    // Tick only acts when no higher-priority request shares its cycle
    assign w_tick_run = tick_1s && !clear && !load && !start && !pause
                     && (r_state == ST_RUN);
    assign w_trig     = reset_n && w_tick_run && w_rem_one;
    assign w_clr      = !reset_n || clear;

    alarm_stretch #(
        .ALARM_LEN(ALARM_LEN)
    ) u_stretch (
        .i_clk    (clk_50m),
        .i_trigger(w_trig),
        .i_clear  (w_clr),
        .o_level  (w_level),
        .o_last   (w_last)
    );

    always_ff @(posedge clk_50m) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_hh       <= '0;
            r_mm       <= '0;
            r_ss       <= '0;
            r_sh_hh    <= '0;
            r_sh_mm    <= '0;
            r_sh_ss    <= '0;
            r_expired  <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_expired  <= 1'b0;
            r_load_err <= 1'b0;
            if ((r_state == ST_ALARM) && w_last) begin
                r_state <= ST_IDLE;
            end
            if (clear) begin
                r_state <= ST_IDLE;
                r_hh    <= '0;
                r_mm    <= '0;
                r_ss    <= '0;
            end else if (load) begin
                if (w_editable && w_load_ok) begin
                    r_hh    <= load_hh;
                    r_mm    <= load_mm;
                    r_ss    <= load_ss;
                    r_sh_hh <= load_hh;
                    r_sh_mm <= load_mm;
                    r_sh_ss <= load_ss;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (start) begin
                if (w_editable && !w_rem_zero) begin
                    r_state <= ST_RUN;
                end else if (w_editable || (r_state == ST_ALARM)) begin
                    r_load_err <= 1'b1;
                end
            end else if (pause) begin
                if (r_state == ST_RUN) begin
                    r_state <= ST_PAUSED;
                end
            end else if (w_tick_run && !w_rem_zero) begin
                if (w_rem_one) begin
                    r_expired <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    r_hh <= r_sh_hh;
                    r_mm <= r_sh_mm;
                    r_ss <= r_sh_ss;
`else
                    r_hh    <= '0;
                    r_mm    <= '0;
                    r_ss    <= '0;
                    r_state <= ST_ALARM;
`endif
                end else begin
                    r_hh <= w_dec_hh;
                    r_mm <= w_dec_mm;
                    r_ss <= w_dec_ss;
                end
            end
        end
    end

    assign rem_hh   = r_hh;
    assign rem_mm   = r_mm;
    assign rem_ss   = r_ss;
    assign busy     = (r_state == ST_RUN) || (r_state == ST_PAUSED);
    assign expired  = r_expired;
    assign alarm    = w_level;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_countdown_alarm.sv
// Directed and random checks of countdown_alarm against a seconds-based model.
// Honours COUNTDOWN_AUTO_RELOAD_EN for both expectations and directed cases.
module tb_countdown_alarm;

    localparam int MH = 24;
    localparam int AL = 50;

    logic       clk_50m = 1'b0;
    logic       reset_n, tick_1s, load, start, pause, clear;
    logic [4:0] load_hh;
    logic [5:0] load_mm, load_ss;
    logic [4:0] rem_hh;
    logic [5:0] rem_mm, rem_ss;
    logic       busy, expired, alarm, load_err;

    countdown_alarm #(.MAX_HOURS(MH), .ALARM_LEN(AL)) dut (
        .clk_50m (clk_50m),
        .reset_n (reset_n),
        .tick_1s (tick_1s),
        .load    (load),
        .load_hh (load_hh),
        .load_mm (load_mm),
        .load_ss (load_ss),
        .start   (start),
        .pause   (pause),
        .clear   (clear),
        .rem_hh  (rem_hh),
        .rem_mm  (rem_mm),
        .rem_ss  (rem_ss),
        .busy    (busy),
        .expired (expired),
        .alarm   (alarm),
        .load_err(load_err)
    );

    always #10 clk_50m = ~clk_50m;

    int total = 0;
    int bad   = 0;

    // Model: 0 idle, 1 run, 2 paused, 3 alarm; time held as total seconds
    int m_st, m_rem, m_sh, m_left;
    bit m_exp, m_err;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int st0;
        if (!reset_n) begin
            m_st = 0; m_rem = 0; m_sh = 0; m_left = 0;
            m_exp = 0; m_err = 0;
            return;
        end
        st0 = m_st;
        m_exp = 0;
        m_err = 0;
        if (m_left > 0) begin
            m_left--;
            if (st0 == 3 && m_left == 0) m_st = 0;
        end
        if (clear) begin
            m_st = 0; m_rem = 0; m_left = 0;
        end else if (load) begin
            if ((st0 == 0 || st0 == 2) && int'(load_hh) < MH
                && int'(load_mm) < 60 && int'(load_ss) < 60) begin
                m_rem = int'(load_hh) * 3600 + int'(load_mm) * 60
                      + int'(load_ss);
                m_sh = m_rem;
            end else begin
                m_err = 1;
            end
        end else if (start) begin
            if (st0 == 0 || st0 == 2) begin
                if (m_rem != 0) m_st = 1;
                else m_err = 1;
            end else if (st0 == 3) begin
                m_err = 1;
            end
        end else if (pause) begin
            if (st0 == 1) m_st = 2;
        end else if (tick_1s && st0 == 1 && m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_exp = 1;
                m_left = AL;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                m_rem = m_sh;
`else
                m_st = 3;
`endif
            end
        end
    endtask

    function automatic logic [31:0] model_vec();
        logic [4:0] h;
        logic [5:0] m, s;
        h = 5'(m_rem / 3600);
        m = 6'((m_rem / 60) % 60);
        s = 6'(m_rem % 60);
        return {12'd0, h, m, s, (m_st == 1 || m_st == 2), m_exp,
                (m_left > 0), m_err};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {12'd0, rem_hh, rem_mm, rem_ss, busy, expired, alarm,
                load_err};
    endfunction

    task automatic cyc(input string tag);
        @(posedge clk_50m);
        model_step();
        #1;
        chk(tag, dut_vec(), model_vec());
    endtask

    task automatic drv(input bit c, input bit l, input bit s, input bit p,
                       input bit t, input int h, input int m,
                       input int sec);
        clear = c; load = l; start = s; pause = p; tick_1s = t;
        load_hh = 5'(h); load_mm = 6'(m); load_ss = 6'(sec);
    endtask

    task automatic nop();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        nop();
        reset_n = 1'b0;
        cyc("reset");
        cyc("reset");
        reset_n = 1'b1;
    endtask

    int n;

    initial begin
        reset_n = 1'b0;
        nop();
        m_st = 0; m_rem = 0; m_sh = 0; m_left = 0; m_exp = 0; m_err = 0;
        do_reset();
        chk("reset_outs", dut_vec(), 32'd0);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // Three-second countdown into ALARM, then back to IDLE
        drv(0, 1, 0, 0, 0, 0, 0, 3); cyc("ld3");
        chk("ld3_ss", 32'(rem_ss), 32'd3);
        drv(0, 0, 1, 0, 0, 0, 0, 0); cyc("st3");
        chk("st3_busy", 32'(busy), 32'd1);
        drv(0, 0, 0, 0, 1, 0, 0, 0); cyc("t1");
        chk("t1_ss", 32'(rem_ss), 32'd2);
        nop(); cyc("gap");
        drv(0, 0, 0, 0, 1, 0, 0, 0); cyc("t2");
        chk("t2_ss", 32'(rem_ss), 32'd1);
        drv(0, 0, 0, 0, 1, 0, 0, 0); cyc("t3");
        chk("t3_ss", 32'(rem_ss), 32'd0);
        chk("t3_exp", 32'(expired), 32'd1);
        chk("t3_alarm", 32'(alarm), 32'd1);
        nop();
        n = (alarm === 1'b1) ? 1 : 0;
        cyc("alm");
        chk("exp_1cyc", 32'(expired), 32'd0);
        if (alarm === 1'b1) n++;
        while (alarm === 1'b1 && n < 70) begin
            cyc("alm");
            if (alarm === 1'b1) n++;
        end
        chk("alarm_len", 32'(n), 32'(AL));
        chk("post_alarm_busy", 32'(busy), 32'd0);
        drv(0, 0, 1, 0, 0, 0, 0, 0); cyc("st0_after");
        chk("idle_start_err", 32'(load_err), 32'd1);
`endif

        // Hour borrow
        do_reset();
        drv(0, 1, 0, 0, 0, 1, 0, 0); cyc("ld1h");
        drv(0, 0, 1, 0, 0, 0, 0, 0); cyc("st1h");
        drv(0, 0, 0, 0, 1, 0, 0, 0); cyc("t1h");
        chk("borrow", {15'd0, rem_hh, rem_mm, rem_ss}, {15'd0, 5'd0, 6'd59, 6'd59});

        // Rejected loads and start with zero
        do_reset();
        drv(0, 1, 0, 0, 0, 0, 60, 0); cyc("ld_mm60");
        chk("mm60_err", 32'(load_err), 32'd1);
        chk("mm60_rem", 32'({rem_hh, rem_mm, rem_ss}), 32'd0);
        drv(0, 1, 0, 0, 0, 24, 0, 0); cyc("ld_hh24");
        chk("hh24_err", 32'(load_err), 32'd1);
        nop(); cyc("err_drop");
        chk("err_1cyc", 32'(load_err), 32'd0);
        drv(0, 0, 1, 0, 0, 0, 0, 0); cyc("st_zero");
        chk("stz_err", 32'(load_err), 32'd1);
        chk("stz_busy", 32'(busy), 32'd0);
        drv(0, 1, 0, 0, 0, 23, 59, 59); cyc("ld_max");
        chk("ld_max", {15'd0, rem_hh, rem_mm, rem_ss}, {15'd0, 5'd23, 6'd59, 6'd59});

        // Pause beats a same-cycle tick
        do_reset();
        drv(0, 1, 0, 0, 0, 0, 0, 5); cyc("ld5");
        drv(0, 0, 1, 0, 0, 0, 0, 0); cyc("st5");
        drv(0, 1, 0, 0, 0, 0, 0, 9); cyc("ld_in_run");
        chk("run_ld_err", 32'(load_err), 32'd1);
        drv(0, 0, 0, 1, 1, 0, 0, 0); cyc("pz");
        chk("pz_ss", 32'(rem_ss), 32'd5);
        drv(0, 0, 0, 0, 1, 0, 0, 0); cyc("pz_t");
        drv(0, 0, 0, 0, 1, 0, 0, 0); cyc("pz_t");
        chk("pz_hold", 32'(rem_ss), 32'd5);
        drv(0, 0, 1, 0, 0, 0, 0, 0); cyc("resume");
        drv(0, 0, 0, 0, 1, 0, 0, 0); cyc("res_t");
        chk("res_ss", 32'(rem_ss), 32'd4);

        // Reset mid-RUN, clear during the alarm
        nop(); reset_n = 1'b0; cyc("rst_run");
        chk("rst_run", dut_vec(), 32'd0);
        reset_n = 1'b1;
        drv(0, 1, 0, 0, 0, 0, 0, 1); cyc("ld1");
        drv(0, 0, 1, 0, 0, 0, 0, 0); cyc("st1");
        drv(0, 0, 0, 0, 1, 0, 0, 0); cyc("exp1");
        nop(); cyc("alm_hold"); cyc("alm_hold");
        drv(1, 0, 0, 0, 0, 0, 0, 0); cyc("clr_alarm");
        chk("clr_alarm", dut_vec(), 32'd0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // Expiry reloads the shadow and keeps running
        do_reset();
        drv(0, 1, 0, 0, 0, 0, 0, 2); cyc("ar_ld");
        drv(0, 0, 1, 0, 0, 0, 0, 0); cyc("ar_st");
        drv(0, 0, 0, 0, 1, 0, 0, 0); cyc("ar_t1");
        drv(0, 0, 0, 0, 1, 0, 0, 0); cyc("ar_t2");
        chk("ar_exp", 32'(expired), 32'd1);
        chk("ar_ss", 32'(rem_ss), 32'd2);
        chk("ar_busy", 32'(busy), 32'd1);
        nop();
        n = (alarm === 1'b1) ? 1 : 0;
        while (alarm === 1'b1 && n < 70) begin
            cyc("ar_alm");
            if (alarm === 1'b1) n++;
        end
        chk("ar_alarm_len", 32'(n), 32'(AL));
        chk("ar_busy_end", 32'(busy), 32'd1);
`endif

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            reset_n = ($urandom_range(0, 499) != 0);
            clear   = ($urandom_range(0, 79) == 0);
            load    = ($urandom_range(0, 15) == 0);
            start   = ($urandom_range(0, 7) == 0);
            pause   = ($urandom_range(0, 31) == 0);
            tick_1s = ($urandom_range(0, 2) == 0);
            load_hh = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
            load_mm = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            load_ss = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                                  : 6'($urandom_range(0, 4));
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/countdown_alarm.md
COUNTDOWN_ALARM -- requirements
Module: countdown_alarm

Interface
REQ-001 SHALL provide parameter MAX_HOURS, default 24, meaning exclusive upper bound of the loadable hour value.
REQ-002 SHALL provide parameter ALARM_LEN, default 50, meaning the number of clk_50m cycles alarm stays high; legal range 1..255.
REQ-003 SHALL have ports as below, with one clock and a synchronous, active-low reset:
- clk_50m  input  1  sole clock, rising edge
- reset_n  input  1  synchronous active-low reset
- tick_1s  input  1  one-cycle pulse per second, driven from the timer block's one_sec_timer
- load  input  1  load request
- load_hh  input  5  hours to load
- load_mm  input  6  minutes to load
- load_ss  input  6  seconds to load
- start  input  1  start or resume request
- pause  input  1  pause request
- clear  input  1  abort to IDLE
- rem_hh  output  5  remaining hours
- rem_mm  output  6  remaining minutes
- rem_ss  output  6  remaining seconds
- busy  output  1  high in RUN or PAUSED
- expired  output  1  one-cycle pulse when the count reaches zero
- alarm  output  1  level, ALARM_LEN cycles long
- load_err  output  1  one-cycle pulse on a rejected load or start

Function
REQ-004 SHALL implement FSM states IDLE, RUN, PAUSED and ALARM.
REQ-005 SHALL apply per-cycle request priority clear > load > start > pause > tick_1s; a lower-priority request in the same cycle is dropped.
REQ-006 SHALL accept load only in IDLE or PAUSED, and only if load_hh < MAX_HOURS, load_mm <= 59 and load_ss <= 59; an accepted load updates rem_* and the reload shadow on the next edge.
REQ-007 SHALL reject an out-of-range load, or a load in RUN or ALARM: rem_* are unchanged and load_err pulses for 1 cycle.
REQ-008 SHALL, on start in IDLE or PAUSED with rem != 00:00:00, enter RUN on the next edge; start with rem == 0 pulses load_err and the state stays put.
REQ-009 SHALL, on pause in RUN, enter PAUSED with rem_* frozen; pause in any other state is ignored.
REQ-010 SHALL, on each tick_1s in RUN, decrement rem by one second with borrow (ss 0->59 borrows mm; mm 0->59 borrows hh); rem_* update on the edge after the tick (1-cycle latency).
REQ-011 SHALL, when a tick drives rem from 00:00:01 to 00:00:00, pulse expired in the same cycle rem becomes zero and assert alarm from that cycle for exactly ALARM_LEN cycles.
REQ-012 SHALL ignore tick_1s in IDLE, PAUSED and ALARM.
REQ-013 SHALL, on clear in any state, enter IDLE, zero rem_*, and drop alarm, expired and load_err on the next edge; the reload shadow is retained.
REQ-014 SHALL drive busy combinationally from state (RUN or PAUSED); all other outputs SHALL be registered.
REQ-015 SHALL hold state in ALARM until the alarm count ends, then enter IDLE with rem == 0; start and load during ALARM are rejected with load_err.

Reset
REQ-016 SHALL, while reset_n is low at a clk_50m edge, set state=IDLE, rem_*=0, shadow=0, expired=0, alarm=0 and load_err=0.
REQ-017 SHALL give reset priority over every input, including mid-RUN and mid-ALARM.

Configuration
REQ-018 SHALL recognise macro COUNTDOWN_AUTO_RELOAD_EN.
REQ-019 SHALL, when COUNTDOWN_AUTO_RELOAD_EN is defined, reload the shadow value into rem on expiry and stay in RUN, with the alarm count running in parallel; a tick arriving during the alarm decrements normally; ALARM is unused.
REQ-020 SHALL, when COUNTDOWN_AUTO_RELOAD_EN is undefined, behave per REQ-011 and REQ-015.

Structure
REQ-021 SHALL place the state enum typedef, the field widths (5/6/6) and the constants SEC_MAX=59 and MIN_MAX=59 in shared package countdown_pkg.
REQ-022 SHALL implement the alarm length counter as sub-module alarm_stretch (inputs: trigger, clear; output: level for ALARM_LEN cycles; retriggering restarts the count).

Verification
REQ-023 SHALL verify: load 00:00:03, start, three ticks -> rem 02,01,00; expired 1 cycle; alarm high 50 cycles; then IDLE, busy=0.
REQ-024 SHALL verify: load 01:00:00, start, one tick -> rem 00:59:59.
REQ-025 SHALL verify: load_mm=60, or load_hh=24 -> load_err pulse, rem unchanged; start with rem=0 -> load_err, state IDLE.
REQ-026 SHALL verify: RUN at 00:00:05, pause together with tick -> PAUSED, rem stays 00:00:05; two ticks ignored; start then tick -> 00:00:04.
REQ-027 SHALL verify: reset_n low mid-RUN and clear during ALARM -> all outputs zero next edge, state IDLE.
REQ-028 SHALL verify with COUNTDOWN_AUTO_RELOAD_EN: load 00:00:02, start, two ticks -> expired pulse, rem 00:00:02, busy=1, alarm 50 cycles.
